// File: rtl/sync_inp_buf.sv
// Clocked router input buffer: PD-deep {eof,data} FIFO, XY route decode of head flits, faulty-frame drop.
// Optional macro LOOKAHEAD_ROUTE_EN decodes at push time into a per-entry tag and removes the ROUTE cycle.
module sync_inp_buf #(
  parameter int DIR = 0,
  parameter int DW  = 32,
  parameter int AW  = 4,
  parameter int PD  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_eof,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_eof,
  input  logic [AW-1:0] addrx,
  input  logic [AW-1:0] addry,
  output logic [4:0]    deco,
  output logic          rt_err,
  output logic [7:0]    err_cnt
);

  localparam int PW = $clog2(PD);
`ifdef LOOKAHEAD_ROUTE_EN
  localparam int EW = DW + 5;
`else
  localparam int EW = DW + 1;
  localparam logic [1:0] S_ROUTE = 2'd1;
`endif
  localparam logic [2:0] DIR_C  = 3'(DIR);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FWD  = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  function automatic logic [2:0] route_target(input logic [2*AW-1:0] xy,
                                              input logic [AW-1:0] ax,
                                              input logic [AW-1:0] ay);
    logic [AW-1:0] tx;
    logic [AW-1:0] ty;
    tx = xy[AW-1:0];
    ty = xy[2*AW-1:AW];
    if (tx > ax)      route_target = 3'd3;
    else if (tx < ax) route_target = 3'd1;
    else if (ty > ay) route_target = 3'd2;
    else if (ty < ay) route_target = 3'd0;
    else              route_target = 3'd4;
  endfunction

  // U-turns are illegal everywhere; a Y-dimension input may not turn back into X.
  function automatic logic route_illegal(input logic [2:0] tgt);
    route_illegal = (tgt == DIR_C) ||
                    (((DIR_C == 3'd0) || (DIR_C == 3'd2)) && ((tgt == 3'd1) || (tgt == 3'd3)));
  endfunction

  logic [EW-1:0] mem_q [PD];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [1:0]    state_q, state_d;
  logic [4:0]    deco_q, deco_d;
  logic          rt_err_q, rt_err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          empty_s, full_s, push_s, pop_s;
  logic [EW-1:0] front_s, wr_entry_s;
  logic [2:0]    dec_tgt_s;
  logic          dec_err_s;

  assign empty_s   = (cnt_q == {(PW+1){1'b0}});
  assign full_s    = (cnt_q == (PW+1)'(PD));
  assign in_ready  = rst_n & ~full_s;
  assign push_s    = in_valid & in_ready;
  assign front_s   = mem_q[rd_ptr_q];
  assign out_data  = front_s[DW-1:0];
  assign out_eof   = front_s[DW];
  assign out_valid = (state_q == S_FWD) & ~empty_s;
  assign deco      = deco_q;
  assign rt_err    = rt_err_q;
  assign err_cnt   = err_cnt_q;

`ifdef LOOKAHEAD_ROUTE_EN
  logic [2:0] push_tgt_s;
  assign push_tgt_s = route_target(in_data[2*AW-1:0], addrx, addry);
  assign wr_entry_s = {route_illegal(push_tgt_s), push_tgt_s, in_eof, in_data};
  assign dec_tgt_s  = front_s[DW+3:DW+1];
  assign dec_err_s  = front_s[DW+4];
`else
  assign wr_entry_s = {in_eof, in_data};
  assign dec_tgt_s  = route_target(front_s[2*AW-1:0], addrx, addry);
  assign dec_err_s  = route_illegal(dec_tgt_s);
`endif

  // Pop source: crossbar handshake while forwarding, self-drain while dropping.
  always_comb begin
    pop_s = 1'b0;
    if (state_q == S_FWD) pop_s = out_valid & out_ready;
    else if (state_q == S_DROP) pop_s = ~empty_s;
    else pop_s = 1'b0;
  end

  // FIFO pointer and occupancy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_s) wr_ptr_d = wr_ptr_q + PW'(1);
    else wr_ptr_d = wr_ptr_q;
    if (pop_s) rd_ptr_d = rd_ptr_q + PW'(1);
    else rd_ptr_d = rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Frame FSM: route the head, then forward or drop until the eof flit leaves.
  always_comb begin
    state_d   = state_q;
    deco_d    = deco_q;
    rt_err_d  = rt_err_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!empty_s) begin
`ifdef LOOKAHEAD_ROUTE_EN
          if (dec_err_s) begin
            state_d  = S_DROP;
            rt_err_d = 1'b1;
          end else begin
            state_d = S_FWD;
            deco_d  = 5'(5'b00001 << dec_tgt_s);
          end
`else
          state_d = S_ROUTE;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
`ifndef LOOKAHEAD_ROUTE_EN
      S_ROUTE: begin
        if (dec_err_s) begin
          state_d  = S_DROP;
          rt_err_d = 1'b1;
        end else begin
          state_d = S_FWD;
          deco_d  = 5'(5'b00001 << dec_tgt_s);
        end
      end
`endif
      S_FWD: begin
        if (pop_s && front_s[DW]) begin
          state_d = S_IDLE;
          deco_d  = 5'b00000;
        end else begin
          state_d = S_FWD;
        end
      end
      S_DROP: begin
        if (pop_s && front_s[DW]) begin
          state_d  = S_IDLE;
          rt_err_d = 1'b0;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          else err_cnt_d = err_cnt_q;
        end else begin
          state_d = S_DROP;
        end
      end
      default: begin
        state_d  = S_IDLE;
        deco_d   = 5'b00000;
        rt_err_d = 1'b0;
      end
    endcase
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_ptr_q] <= wr_entry_s;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= {PW{1'b0}};
      rd_ptr_q  <= {PW{1'b0}};
      cnt_q     <= {(PW+1){1'b0}};
      state_q   <= S_IDLE;
      deco_q    <= 5'b00000;
      rt_err_q  <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      deco_q    <= deco_d;
      rt_err_q  <= rt_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: doc/sync_inp_buf.md
Name: sync_inp_buf

Overview:
- Clocked, parametrised successor of the asynchronous wormhole/SDM input buffer.
- Sits between a link input and the crossbar/arbiter of a router port.
- Buffers `{eof, data}` flits in a PD-deep FIFO and decodes the XY route of each head flit.
- Holds a one-hot output request for the whole frame; frames with illegal routes are discarded and counted.

Parameters:
- DIR, 0, incoming port: 0=south, 1=west, 2=north, 3=east, 4=local.
- DW, 32, flit data width; must be ≥ 2*AW.
- AW, 4, binary address width per dimension.
- PD, 4, FIFO depth in flits; ≥ 2, power of two.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream flit valid.
- in_ready  output  1  buffer can accept a flit.
- in_data  input  DW  flit payload; in a head flit, x target = [AW-1:0], y target = [2AW-1:AW].
- in_eof  input  1  last flit of frame.
- out_valid  output  1  front flit available to crossbar.
- out_ready  output→input  1  crossbar accepts (grant AND downstream ready).
- out_data  output  DW  front flit payload.
- out_eof  output  1  front flit eof.
- addrx  input  AW  local router x.
- addry  input  AW  local router y.
- deco  output  5  one-hot output-port request, indexed by the DIR encoding.
- rt_err  output  1  high while a faulty frame is being dropped.
- err_cnt  output  8  saturating count of dropped frames.

Note: out_ready is an input of this block.

Behaviour:
- Reset (async, rst_n=0), immediate: FIFO emptied, state IDLE, in_ready=0 while reset asserted, out_valid=0, deco=0, rt_err=0, err_cnt=0. Reset mid-frame discards all stored flits; the next accepted flit is a head.
- Handshakes: push when in_valid&in_ready; pop when out_valid&out_ready (FWD) or internally (DROP).
- in_ready = !full, combinational from occupancy. Push and pop in the same cycle are allowed when not full; when full, push is blocked even if a pop occurs.
- No fall-through: a pushed flit reaches the FIFO front on the next cycle. Occupancy wraps pointers modulo PD.
- Head flit: the first flit after reset or after an eof flit leaves the front.
- Route decode, on the front head flit (tx=data[AW-1:0], ty=data[2AW-1:AW]):
  - tx>addrx → east(3); tx<addrx → west(1).
  - tx==addrx: ty>addry → north(2); ty<addry → south(0); equal → local(4).
- Illegal routes: target == DIR (U-turn or local loopback), or DIR∈{0,2} with target east/west (XY violation).
- FSM:
  - IDLE: wait for non-empty FIFO; head at front → ROUTE.
  - ROUTE (1 cycle): register decision. Legal → FWD, deco=onehot(target). Illegal → DROP, rt_err=1.
  - FWD: out_valid = !empty, out_data/out_eof = front; deco held constant. Pop of eof flit → IDLE, deco=0 from the next cycle.
  - DROP: out_valid=0; pop one flit per cycle when non-empty. Pop of eof flit → IDLE, rt_err=0, err_cnt+1 (saturate at 255).
- Single-flit frame (head has eof=1): one ROUTE cycle, then forwarded or dropped as one flit.
- FWD with empty FIFO: out_valid=0, deco stays asserted (frame in progress).
- Latency, without the optional feature: push of head at edge N → front at N+1 → deco/out_valid at N+2.
- out_valid is never high outside FWD; deco is never nonzero outside FWD.

Optional Feature:
- Macro: LOOKAHEAD_ROUTE_EN.
- Defined:
  - Route decision and legality are computed on in_data at push time and stored as a 4-bit tag per FIFO entry (3-bit target, 1-bit error).
  - The ROUTE state is removed: IDLE→FWD/DROP in the same cycle the head reaches the front.
  - deco/out_valid are asserted one cycle after the push (N+1).
  - Adds PD*4 storage bits.
- Undefined: ROUTE cycle present as above; no tag storage.

Test Plan:
- Reset/idle: DIR=4, addr (2,2); reset, then no input → in_ready=1, out_valid=0, deco=0, err_cnt=0.
- Basic forward: DIR=4, addr (2,2); 3-flit frame, head x=5 y=1, out_ready=1 → deco=5'b01000 at N+2 (N+1 with macro); 3 flits out in order; deco=0 the cycle after the eof pop.
- Backpressure/full: PD=4, out_ready=0, push 6-flit frame → in_ready=0 after 4 pushes; raising out_ready drains in order with no loss or duplication.
- Illegal route: DIR=0, addr (2,2); 2-flit frame to x=3 → rt_err=1 for 2 cycles, out_valid=0, err_cnt=1. A following legal frame to (2,0) forwards with deco=5'b00001? No: (2,0) from DIR=0 is south = U-turn, so it drops, err_cnt=2.
- Back-to-back frames: single-flit frame to local (addr match, DIR=1), then immediately a 2-flit frame to east → deco 5'b10000, then 5'b01000; no flit of frame 2 leaves while deco shows frame 1.
- Async reset mid-frame: assert rst_n=0 between flit 2 and 3 of FWD → outputs clear without a clock edge; after release, the next pushed flit is routed as a head.
